// File: rtl/store_align.sv
// Store lane placement: shifts right-justified store data into byte lanes,
// builds write strobes and issues one or two word-aligned bus beats.
module store_align #(
  parameter int MISALIGNED_EN = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [2:0]  req_sel_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state, state_n;

  logic        valid_q, valid_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic [3:0]  wstrb_q, wstrb_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  // Second-beat payload parked until the first beat is accepted.
  logic [31:0] hi_addr_q, hi_addr_n;
  logic [31:0] hi_data_q, hi_data_n;
  logic [3:0]  hi_strb_q, hi_strb_n;
  logic        split_q, split_n;

  logic        accept;
  logic        legal;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] byte_mask;
  logic [31:0] data_m;
  logic [63:0] d64;
  logic [7:0]  s8;
  logic        misal;
  logic [31:0] base;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign off         = req_addr_i[1:0];
  assign base        = {req_addr_i[31:2], 2'b00};

  always_comb begin
    mask  = 4'b0000;
    legal = 1'b1;
    unique case (req_sel_i)
      3'b000:  mask = 4'b0001;
      3'b001:  mask = 4'b0011;
      3'b010:  mask = 4'b1111;
      default: legal = 1'b0;
    endcase
  end

  assign byte_mask = {{8{mask[3]}}, {8{mask[2]}},
                      {8{mask[1]}}, {8{mask[0]}}};
  assign data_m    = req_data_i & byte_mask;
  assign d64       = {32'd0, data_m} << {off, 3'b000};
  assign s8        = {4'd0, mask} << off;
  assign misal     = (s8[7:4] != 4'd0);

  always_comb begin
    state_n   = state;
    valid_n   = valid_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    hi_addr_n = hi_addr_q;
    hi_data_n = hi_data_q;
    hi_strb_n = hi_strb_q;
    split_n   = split_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!legal || (misal && MISALIGNED_EN == 0)) begin
            state_n = RESP;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n   = BEAT0;
            valid_n   = 1'b1;
            addr_n    = base;
            wdata_n   = d64[31:0];
            wstrb_n   = s8[3:0];
            hi_addr_n = base + 32'd4;
            hi_data_n = d64[63:32];
            hi_strb_n = s8[7:4];
            split_n   = misal;
          end
        end
      end
      BEAT0: begin
        if (mem_ready_i) begin
          if (split_q) begin
            // Valid stays high; only the payload moves to the upper word.
            state_n = BEAT1;
            addr_n  = hi_addr_q;
            wdata_n = hi_data_q;
            wstrb_n = hi_strb_q;
          end else begin
            state_n = RESP;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready_i) begin
          state_n = RESP;
          valid_n = 1'b0;
          done_n  = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hi_addr_q <= 32'd0;
      hi_data_q <= 32'd0;
      hi_strb_q <= 4'd0;
      split_q   <= 1'b0;
    end else begin
      state     <= state_n;
      valid_q   <= valid_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      wstrb_q   <= wstrb_n;
      done_q    <= done_n;
      err_q     <= err_n;
      hi_addr_q <= hi_addr_n;
      hi_data_q <= hi_data_n;
      hi_strb_q <= hi_strb_n;
      split_q   <= split_n;
    end
  end

  assign mem_valid_o = valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align: lane placement, backpressure,
// split beats with address wrap, rejections and mid-beat reset.
module tb_store_align;

  logic        clk;
  logic        rst;
  logic        v1, v0;
  logic [31:0] addr, data;
  logic [2:0]  sel;
  logic        mrdy;

  logic        rdy1, mv1, done1, err1;
  logic [31:0] ma1, md1;
  logic [3:0]  ms1;
  logic        rdy0, mv0, done0, err0;
  logic [31:0] ma0, md0;
  logic [3:0]  ms0;

  int errors = 0;
  int checks = 0;

  store_align #(.MISALIGNED_EN(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v1), .req_ready_o(rdy1),
    .req_addr_i(addr), .req_data_i(data), .req_sel_i(sel),
    .mem_valid_o(mv1), .mem_ready_i(mrdy),
    .mem_addr_o(ma1), .mem_wdata_o(md1), .mem_wstrb_o(ms1),
    .done_o(done1), .err_o(err1)
  );

  store_align #(.MISALIGNED_EN(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v0), .req_ready_o(rdy0),
    .req_addr_i(addr), .req_data_i(data), .req_sel_i(sel),
    .mem_valid_o(mv0), .mem_ready_i(mrdy),
    .mem_addr_o(ma0), .mem_wdata_o(md0), .mem_wstrb_o(ms0),
    .done_o(done0), .err_o(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] s, input bit to0);
    @(negedge clk);
    addr = a;
    data = d;
    sel  = s;
    if (to0) v0 = 1'b1;
    else v1 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy1, mv1, done1, err1} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 1000", {rdy1, mv1, done1, err1});
    end
    checks++;
    if ({ma1, md1, ms1} !== 68'd0) begin
      errors++;
      $display("FAIL reset_bus got %h %h %b want zeros", ma1, md1, ms1);
    end
    rst = 1'b0;
  endtask

  task automatic test_aligned_word();
    mrdy = 1'b1;
    issue(32'h1000, 32'hDEADBEEF, 3'b010, 1'b0);
    @(negedge clk);
    checks++;
    if ({mv1, ma1, md1, ms1} !== {1'b1, 32'h1000, 32'hDEADBEEF, 4'b1111}) begin
      errors++;
      $display("FAIL word_beat got v=%b %h %h %b want 1 1000 deadbeef 1111",
               mv1, ma1, md1, ms1);
    end
    checks++;
    if (rdy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL word_busy got rdy=%b done=%b want 0 0", rdy1, done1);
    end
    @(negedge clk);
    checks++;
    if ({done1, err1, mv1} !== 3'b100) begin
      errors++;
      $display("FAIL word_done got %b want 100", {done1, err1, mv1});
    end
    @(negedge clk);
    checks++;
    if ({done1, rdy1} !== 2'b01) begin
      errors++;
      $display("FAIL word_idle got done=%b rdy=%b want 0 1", done1, rdy1);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] exp_d [4] = '{32'h000000AB, 32'h0000AB00,
                               32'h00AB0000, 32'hAB000000};
    logic [3:0]  exp_s [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mrdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(32'h2000 + i, 32'h123456AB, 3'b000, 1'b0);
      @(negedge clk);
      checks++;
      if ({mv1, ma1, md1, ms1} !== {1'b1, 32'h2000, exp_d[i], exp_s[i]}) begin
        errors++;
        $display("FAIL byte_off%0d got v=%b %h %h %b want 1 2000 %h %b",
                 i, mv1, ma1, md1, ms1, exp_d[i], exp_s[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    mrdy = 1'b0;
    issue(32'h3002, 32'hFFFFCAFE, 3'b001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mv1, ma1, md1, ms1, done1} !==
          {1'b1, 32'h3000, 32'hCAFE0000, 4'b1100, 1'b0}) begin
        errors++;
        $display("FAIL half_hold%0d got v=%b %h %h %b d=%b want 1 3000 cafe0000 1100 0",
                 i, mv1, ma1, md1, ms1, done1);
      end
    end
    mrdy = 1'b1;
    @(posedge clk);
    if (mv1) hs++;
    @(negedge clk);
    checks++;
    if ({done1, err1, mv1} !== 3'b100 || hs != 1) begin
      errors++;
      $display("FAIL half_done got %b hs=%0d want 100 hs=1",
               {done1, err1, mv1}, hs);
    end
    @(negedge clk);
  endtask

  task automatic test_split_wrap();
    mrdy = 1'b1;
    issue(32'hFFFFFFFD, 32'h11223344, 3'b010, 1'b0);
    @(negedge clk);
    checks++;
    if ({mv1, ma1, md1, ms1} !== {1'b1, 32'hFFFFFFFC, 32'h22334400, 4'b1110}) begin
      errors++;
      $display("FAIL split_b0 got v=%b %h %h %b want 1 fffffffc 22334400 1110",
               mv1, ma1, md1, ms1);
    end
    @(negedge clk);
    checks++;
    if ({mv1, ma1, md1, ms1, done1} !==
        {1'b1, 32'h0, 32'h00000011, 4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL split_b1 got v=%b %h %h %b d=%b want 1 0 11 0001 0",
               mv1, ma1, md1, ms1, done1);
    end
    @(negedge clk);
    checks++;
    if ({done1, err1, mv1} !== 3'b100) begin
      errors++;
      $display("FAIL split_done got %b want 100", {done1, err1, mv1});
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL split_once got done=%b want 0", done1);
    end
  endtask

  task automatic test_reject();
    mrdy = 1'b1;
    issue(32'h4000, 32'h0, 3'b011, 1'b0);
    @(negedge clk);
    checks++;
    if ({mv1, done1, err1} !== 3'b011) begin
      errors++;
      $display("FAIL rej_sel got v/d/e=%b want 011", {mv1, done1, err1});
    end
    @(negedge clk);
    checks++;
    if ({mv1, done1, err1, rdy1} !== 4'b0001) begin
      errors++;
      $display("FAIL rej_sel_after got %b want 0001", {mv1, done1, err1, rdy1});
    end
    issue(32'h4003, 32'h0000BEEF, 3'b001, 1'b1);
    @(negedge clk);
    checks++;
    if ({mv0, done0, err0} !== 3'b011) begin
      errors++;
      $display("FAIL rej_misal got v/d/e=%b want 011", {mv0, done0, err0});
    end
    @(negedge clk);
    issue(32'h4002, 32'h0000BEEF, 3'b001, 1'b1);
    @(negedge clk);
    checks++;
    if ({mv0, ma0, md0, ms0} !== {1'b1, 32'h4000, 32'hBEEF0000, 4'b1100}) begin
      errors++;
      $display("FAIL en0_aligned got v=%b %h %h %b want 1 4000 beef0000 1100",
               mv0, ma0, md0, ms0);
    end
    @(negedge clk);
    checks++;
    if ({done0, err0} !== 2'b10) begin
      errors++;
      $display("FAIL en0_done got %b want 10", {done0, err0});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_beat();
    int seen = 0;
    mrdy = 1'b0;
    issue(32'h5000, 32'h55AA55AA, 3'b010, 1'b0);
    @(negedge clk);
    checks++;
    if (mv1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got v=%b want 1", mv1);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mv1, rdy1, done1} !== 3'b010) begin
      errors++;
      $display("FAIL rst_mid got v/r/d=%b want 010", {mv1, rdy1, done1});
    end
    rst  = 1'b0;
    mrdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done1 || mv1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_quiet got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    rst  = 1'b1;
    v1   = 1'b0;
    v0   = 1'b0;
    addr = '0;
    data = '0;
    sel  = '0;
    mrdy = 1'b0;
    test_reset();
    test_aligned_word();
    test_byte_lanes();
    test_backpressure();
    test_split_wrap();
    test_reject();
    test_reset_mid_beat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_align.md
Name: store_align

Overview:
- Store-side counterpart of the load extension path: takes a register value plus a byte address and access size, and places the data into the correct byte lanes with write strobes.
- Issues the result to the data-memory bus over a valid/ready handshake.
- Sits between the execute stage and the data-memory port.
- Optionally splits a misaligned store into two word-aligned bus beats.

Parameters:
- MISALIGNED_EN, 1, 1 = split misaligned stores into two beats; 0 = reject them with an error and no bus traffic.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- req_valid_i  input  1  store request valid
- req_ready_o  output  1  block can accept a request
- req_addr_i  input  32  byte address
- req_data_i  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- req_sel_i  input  3  size: 000 byte, 001 half, 010 word; all other codes illegal
- mem_valid_o  output  1  bus beat valid
- mem_ready_i  input  1  bus accepts beat
- mem_addr_o  output  32  word-aligned beat address ([1:0]=00)
- mem_wdata_o  output  32  lane-placed write data
- mem_wstrb_o  output  4  byte-lane strobes
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  valid with done_o: request rejected

Behaviour:
- Reset values (clk_i edge with rst_i=1):
  - state=IDLE, req_ready_o=1.
  - mem_valid_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0, done_o=0, err_o=0.
- Reset mid-operation: mem_valid_o drops on the next cycle; the in-flight store is abandoned with no done_o.
- States: IDLE, BEAT0, BEAT1, RESP.
- req_ready_o=1 only in IDLE. A request is accepted when req_valid_i && req_ready_o.
- Alignment math, registered at accept:
  - off = addr[1:0]; size mask m = 0001 / 0011 / 1111 for byte / half / word.
  - 64-bit data d64 = zero-extended masked data << (8*off).
  - 8-bit strobe s8 = m << off.
  - Beat0: addr {addr[31:2],00}, wdata d64[31:0], wstrb s8[3:0].
  - Beat1: addr beat0+4 (mod 2^32, so it wraps), wdata d64[63:32], wstrb s8[7:4].
  - Data bits outside the access size are ignored. Unstrobed lanes of mem_wdata_o are 0.
- Misaligned = s8[7:4] != 0 (half at off 3; word at off 1, 2 or 3).
- Transitions from IDLE on accept:
  - Illegal sel, or misaligned with MISALIGNED_EN=0 → RESP with err=1. No mem_valid_o ever asserted.
  - Otherwise → BEAT0, with mem_valid_o=1 in the next cycle (1-cycle registered latency).
- BEAT0:
  - Hold mem_valid_o and all mem_* outputs stable until mem_ready_i.
  - On handshake: go to BEAT1 if misaligned, else RESP.
- BEAT1: mem_valid_o remains high continuously across the beat0→beat1 switch. Outputs switch to beat1 values the cycle after the beat0 handshake. On handshake → RESP.
- RESP:
  - done_o=1 for exactly one cycle; err_o valid alongside it.
  - mem_valid_o=0.
  - Next state IDLE; req_ready_o reasserts the cycle after done_o.
- Throughput: minimum 3 cycles per aligned store (accept, beat, resp). No back-to-back overlap.
- mem_valid_o never drops without a handshake, except on reset.
- done_o and err_o are 0 in every state except RESP.

Test Plan:
- Aligned word: addr 0x1000, data 0xDEADBEEF, sel 010, mem_ready_i=1 → one beat: addr 0x1000, wdata 0xDEADBEEF, wstrb 1111. done_o pulses 2 cycles after accept, err_o=0.
- Byte lanes: sel 000, data 0x123456AB at addr 0x2000, 0x2001, 0x2002, 0x2003 → wdata 0x000000AB / 0x0000AB00 / 0x00AB0000 / 0xAB000000, wstrb 0001 / 0010 / 0100 / 1000.
- Half at off 2 with backpressure: addr 0x3002, data 0xFFFFCAFE, sel 001, mem_ready_i low for 3 cycles → wdata 0xCAFE0000, wstrb 1100, outputs held stable throughout. Single handshake, then done_o.
- Misaligned word split (MISALIGNED_EN=1): addr 0xFFFFFFFD, data 0x11223344, sel 010 → beat0: addr 0xFFFFFFFC, wdata 0x44332211... rather lanes 1-3 = 0x44,0x33,0x22: wdata 0x22334400, wstrb 1110. Beat1: addr 0x00000000 (wrap), wdata 0x00000011, wstrb 0001. One done_o, err_o=0.
- Rejections:
  - sel 011 at addr 0x4000 → no mem_valid_o; done_o=1, err_o=1 one cycle after accept.
  - MISALIGNED_EN=0 with half at addr 0x4003 → same error response.
- Reset mid-beat: rst_i asserted while in BEAT0 with mem_ready_i=0 → next cycle mem_valid_o=0, req_ready_o=1, done_o never pulses.
